// File: rtl/lm_decoder_pkg.sv
// lm_decoder_pkg: shared types and helpers for the load-modulator subcarrier decoder.
//   lm_token_t      - output token {data, eof}
//   lm_state_t      - decoder state {IDLE, BIT, ERR_WAIT}
//   lm_expected_sc  - expected subcarrier level at sample idx within a half bit
package lm_decoder_pkg;

    typedef struct packed {
        logic data;
        logic eof;
    } lm_token_t;

    typedef enum logic [1:0] {
        IDLE,
        BIT,
        ERR_WAIT
    } lm_state_t;

    // Subcarrier is high for the first half of each subcarrier period.
    function automatic logic lm_expected_sc(input int unsigned idx, input int unsigned sc_ticks);
        return (idx % sc_ticks) < (sc_ticks / 2);
    endfunction

endpackage

// File: rtl/lm_dec_fifo.sv
// lm_dec_fifo: synchronous show-ahead token FIFO with async active-low reset.
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_en, wr_data     - push; ignored when full unless a pop happens the same cycle
//   rd_en, rd_data     - pop; rd_data always shows the head entry
//   full, empty        - occupancy flags
module lm_dec_fifo
    import lm_decoder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en,
    input  lm_token_t wr_data,
    input  logic      rd_en,
    output lm_token_t rd_data,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    lm_token_t     mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          wr_ok, rd_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // A push while full is taken only if the head leaves in the same cycle.
    always_comb begin
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/lm_subcarrier_decoder.sv
// lm_subcarrier_decoder: in-loop monitor decoding the PICC load-modulator stream
// (Manchester bits, OOK subcarrier). Each bit period is compared sample by sample
// against the P1, P0 and idle patterns; the winner within ERR_TOL mismatches
// becomes a data or end-of-frame token on a valid/ready output.
//   clk, rst_n                    - carrier-rate clock, async active-low reset
//   enable                        - low forces IDLE and clears the bit counters
//   tx_out                        - modulator output being decoded
//   out_valid/out_ready           - token handshake; out_data, out_eof token fields
//   rx_active                     - high while in BIT state
//   err_pattern, err_overflow     - one-cycle error pulses
// Build option: LM_DECODER_FIFO_EN selects a FIFO_DEPTH-entry output FIFO instead
// of a single output register.
module lm_subcarrier_decoder
    import lm_decoder_pkg::*;
#(
    parameter int SC_TICKS    = 16,
    parameter int SC_PER_HALF = 4,
    parameter int ERR_TOL     = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic tx_out,
    output logic out_valid,
    input  logic out_ready,
    output logic out_data,
    output logic out_eof,
    output logic rx_active,
    output logic err_pattern,
    output logic err_overflow
);
    localparam int HALF_TICKS = SC_TICKS * SC_PER_HALF;
    localparam int BIT_TICKS  = 2 * HALF_TICKS;
    localparam int CW         = $clog2(BIT_TICKS + 1);
    localparam int IW         = $clog2(BIT_TICKS);

    localparam logic [IW-1:0] HALF_IDX = IW'(HALF_TICKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] TOL      = CW'(ERR_TOL);
    localparam logic [CW-1:0] ZLAST    = CW'(BIT_TICKS - 1);

    generate
        if (SC_TICKS < 2 || (SC_TICKS % 2) != 0 || 2 * ERR_TOL >= HALF_TICKS / 2 ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("lm_subcarrier_decoder: illegal parameter combination");
        end
    endgenerate

    lm_state_t     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] mm1_q, mm1_d, mm0_q, mm0_d, mmi_q, mmi_d;
    logic [CW-1:0] mm1_n, mm0_n, mmi_n;
    logic [CW-1:0] zcnt_q, zcnt_d;
    logic          first_q, first_d;
    logic          err_pattern_q, err_overflow_q;

    logic          first_half, sc, e1, e0;
    logic [IW-1:0] half_idx;
    logic          wr_en, pat_err, rd_en, ovf;
    lm_token_t     wr_tok, head_tok;

    // Expected pattern levels for the current sample. Counters include the
    // current sample so the last-sample classification sees the whole bit.
    always_comb begin
        first_half = idx_q < HALF_IDX;
        half_idx   = first_half ? idx_q : idx_q - HALF_IDX;
        sc         = lm_expected_sc(32'(half_idx), SC_TICKS);
        e1         = first_half & sc;
        e0         = !first_half & sc;
        mm1_n      = mm1_q + CW'(tx_out != e1);
        mm0_n      = mm0_q + CW'(tx_out != e0);
        mmi_n      = mmi_q + CW'(tx_out);
    end

    // IDLE always holds idx/counters at zero, so the start sample goes through
    // the same counter path as index 0 of a bit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mm1_d   = mm1_q;
        mm0_d   = mm0_q;
        mmi_d   = mmi_q;
        first_d = first_q;
        zcnt_d  = zcnt_q;
        wr_en   = 1'b0;
        wr_tok  = '0;
        pat_err = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            mm1_d   = '0;
            mm0_d   = '0;
            mmi_d   = '0;
            first_d = 1'b0;
            zcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: if (tx_out) begin
                    state_d = BIT;
                    idx_d   = IW'(1);
                    mm1_d   = mm1_n;
                    mm0_d   = mm0_n;
                    mmi_d   = mmi_n;
                    first_d = 1'b1;
                end
                BIT: if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    mm1_d   = '0;
                    mm0_d   = '0;
                    mmi_d   = '0;
                    first_d = 1'b0;
                    if (mmi_n <= TOL) begin
                        state_d = IDLE;
                        if (first_q) pat_err = 1'b1;
                        else begin
                            wr_en      = 1'b1;
                            wr_tok.eof = 1'b1;
                        end
                    end else if (mm1_n <= TOL) begin
                        // First P1 is the start-of-communication bit.
                        if (!first_q) begin
                            wr_en       = 1'b1;
                            wr_tok.data = 1'b1;
                        end
                    end else if (mm0_n <= TOL) begin
                        if (first_q) begin
                            pat_err = 1'b1;
                            state_d = ERR_WAIT;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end else begin
                        pat_err = 1'b1;
                        state_d = ERR_WAIT;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                    mm1_d = mm1_n;
                    mm0_d = mm0_n;
                    mmi_d = mmi_n;
                end
                ERR_WAIT: begin
                    if (tx_out) zcnt_d = '0;
                    else if (zcnt_q == ZLAST) begin
                        state_d = IDLE;
                        zcnt_d  = '0;
                    end else begin
                        zcnt_d = zcnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            mm1_q          <= '0;
            mm0_q          <= '0;
            mmi_q          <= '0;
            first_q        <= 1'b0;
            zcnt_q         <= '0;
            err_pattern_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mm1_q          <= mm1_d;
            mm0_q          <= mm0_d;
            mmi_q          <= mmi_d;
            first_q        <= first_d;
            zcnt_q         <= zcnt_d;
            err_pattern_q  <= pat_err;
            err_overflow_q <= ovf;
        end
    end

`ifdef LM_DECODER_FIFO_EN
    logic fifo_full, fifo_empty;

    assign rd_en     = !fifo_empty && out_ready;
    assign ovf       = wr_en && fifo_full && !rd_en;
    assign out_valid = !fifo_empty;

    lm_dec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_tok),
        .rd_en   (rd_en),
        .rd_data (head_tok),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
`else
    logic      valid_q, valid_d;
    lm_token_t tok_q, tok_d;
    logic      accept;

    // A held token that is not being taken blocks the incoming one.
    always_comb begin
        rd_en   = valid_q && out_ready;
        accept  = wr_en && (!valid_q || rd_en);
        ovf     = wr_en && valid_q && !rd_en;
        valid_d = accept ? 1'b1 : (rd_en ? 1'b0 : valid_q);
        tok_d   = accept ? wr_tok : tok_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tok_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tok_q   <= tok_d;
        end
    end

    assign out_valid = valid_q;
    assign head_tok  = tok_q;
`endif

    assign out_data     = head_tok.data;
    assign out_eof      = head_tok.eof;
    assign rx_active    = (state_q == BIT);
    assign err_pattern  = err_pattern_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_lm_subcarrier_decoder.sv
// Bench for lm_subcarrier_decoder: three instances (defaults, ERR_TOL=2,
// SC_TICKS=8) share one clock and reset. Stimulus pushes expected tokens into a
// per-instance queue; a negedge monitor pops and compares on each transfer and
// counts error pulses.
module tb_lm_subcarrier_decoder;

    typedef lm_decoder_pkg::lm_token_t tok_t;

`ifdef LM_DECODER_FIFO_EN
    localparam int HOLD = 8;
`else
    localparam int HOLD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] en, tx, rdy;
    logic [2:0] val, dat, eof, act, perr, ovf;

    int   checks = 0;
    int   errors = 0;
    tok_t exp_q [3][$];
    int   pat_cnt [3];
    int   ovf_cnt [3];

    always #5 clk = ~clk;

    lm_subcarrier_decoder dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .tx_out(tx[0]),
        .out_valid(val[0]), .out_ready(rdy[0]), .out_data(dat[0]), .out_eof(eof[0]),
        .rx_active(act[0]), .err_pattern(perr[0]), .err_overflow(ovf[0]));

    lm_subcarrier_decoder #(.ERR_TOL(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .tx_out(tx[1]),
        .out_valid(val[1]), .out_ready(rdy[1]), .out_data(dat[1]), .out_eof(eof[1]),
        .rx_active(act[1]), .err_pattern(perr[1]), .err_overflow(ovf[1]));

    lm_subcarrier_decoder #(.SC_TICKS(8), .SC_PER_HALF(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .tx_out(tx[2]),
        .out_valid(val[2]), .out_ready(rdy[2]), .out_data(dat[2]), .out_eof(eof[2]),
        .rx_active(act[2]), .err_pattern(perr[2]), .err_overflow(ovf[2]));

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    // Monitor: one transfer per negedge with valid && ready (taken on the next posedge).
    always @(negedge clk) begin
        tok_t e;
        for (int k = 0; k < 3; k++) begin
            if (perr[k]) pat_cnt[k]++;
            if (ovf[k]) ovf_cnt[k]++;
            if (val[k] && rdy[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("dut%0d unexpected token", k), int'({dat[k], eof[k]}), -1);
                end else begin
                    e = exp_q[k].pop_front();
                    chk($sformatf("dut%0d token", k), int'({dat[k], eof[k]}), int'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic d, input logic e);
        tok_t t;
        t.data = d;
        t.eof  = e;
        exp_q[k].push_back(t);
    endtask

    // pat: 1 = P1, 0 = P0, 2 = idle. nflip flips samples 0, 70, 120 in turn.
    // nsamp > 0 truncates the bit after that many samples.
    task automatic send_bit(input int k, input int pat, input int sct, input int sph,
                            input int nflip, input int nsamp);
        int   half, n, j;
        logic sc, b;
        half = sct * sph;
        n    = (nsamp == 0) ? 2 * half : nsamp;
        for (int i = 0; i < n; i++) begin
            j  = i % half;
            sc = (j % sct) < (sct / 2);
            if (pat == 1)      b = (i < half) && sc;
            else if (pat == 0) b = (i >= half) && sc;
            else               b = 1'b0;
            if ((nflip >= 1 && i == 0) || (nflip >= 2 && i == 70) || (nflip >= 3 && i == 120))
                b = !b;
            tx[k] = b;
            tick();
        end
        tx[k] = 1'b0;
    endtask

    // SOC, n data bits (bits[0] first), idle bit; expects the data tokens then EOF.
    task automatic frame(input int k, input int sct, input int sph, input int n,
                         input logic [15:0] bits);
        send_bit(k, 1, sct, sph, 0, 0);
        chk($sformatf("dut%0d rx_active after SOC", k), int'(act[k]), 1);
        for (int i = 0; i < n; i++) begin
            push(k, bits[i], 1'b0);
            send_bit(k, bits[i] ? 1 : 0, sct, sph, 0, 0);
        end
        push(k, 1'b0, 1'b1);
        send_bit(k, 2, sct, sph, 0, 0);
        chk($sformatf("dut%0d rx_active after EOF", k), int'(act[k]), 0);
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int p, o;
        logic [15:0] obits;
        en  = 3'b111;
        tx  = 3'b000;
        rdy = 3'b111;
        for (int k = 0; k < 3; k++) begin
            pat_cnt[k] = 0;
            ovf_cnt[k] = 0;
        end
        #2;
        for (int k = 0; k < 3; k++)
            chk($sformatf("dut%0d reset outputs", k),
                int'({val[k], dat[k], eof[k], act[k], perr[k], ovf[k]}), 0);
        #10 rst_n = 1'b1;
        tick();

        // Basic frame: SOC, 1, 0, 1, EOF.
        p = pat_cnt[0];
        frame(0, 16, 4, 3, 16'b101);
        drain(4);
        chk("basic queue drained", exp_q[0].size(), 0);
        chk("basic err_pattern count", pat_cnt[0] - p, 0);

        // ERR_TOL=2: two flips still decode as 0.
        p = pat_cnt[1];
        send_bit(1, 1, 16, 4, 0, 0);
        push(1, 1'b0, 1'b0);
        send_bit(1, 0, 16, 4, 2, 0);
        push(1, 1'b0, 1'b1);
        send_bit(1, 2, 16, 4, 0, 0);
        drain(4);
        chk("tol2 queue drained", exp_q[1].size(), 0);
        chk("tol2 err_pattern count", pat_cnt[1] - p, 0);

        // Three flips: error, ERR_WAIT swallows a P1 and an idle bit.
        p = pat_cnt[1];
        send_bit(1, 1, 16, 4, 0, 0);
        send_bit(1, 0, 16, 4, 3, 0);
        chk("tol3 err_pattern pulse", int'(perr[1]), 1);
        chk("tol3 in ERR_WAIT", int'(act[1]), 0);
        tick();
        chk("tol3 err_pattern one cycle", int'(perr[1]), 0);
        send_bit(1, 1, 16, 4, 0, 0);
        send_bit(1, 2, 16, 4, 0, 0);
        drain(4);
        chk("tol3 err_pattern count", pat_cnt[1] - p, 1);
        frame(1, 16, 4, 1, 16'b1);
        drain(4);
        chk("tol3 recovery drained", exp_q[1].size(), 0);

        // First bit as P0 (sample 0 forced high so the decoder locks on it).
        p = pat_cnt[1];
        send_bit(1, 0, 16, 4, 1, 0);
        chk("p0 first err_pattern", int'(perr[1]), 1);
        chk("p0 first ERR_WAIT", int'(act[1]), 0);
        send_bit(1, 2, 16, 4, 0, 0);
        frame(1, 16, 4, 0, 16'b0);
        drain(4);
        chk("p0 first err_pattern count", pat_cnt[1] - p, 1);
        chk("p0 first drained", exp_q[1].size(), 0);

        // Overflow with out_ready low: 9 data bits + EOF.
        rdy[0] = 1'b0;
        o      = ovf_cnt[0];
        obits  = 16'b1_0100_1101;
        send_bit(0, 1, 16, 4, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i < HOLD) push(0, obits[i], 1'b0);
            send_bit(0, obits[i] ? 1 : 0, 16, 4, 0, 0);
        end
        send_bit(0, 2, 16, 4, 0, 0);
        drain(2);
        chk("overflow pulse count", ovf_cnt[0] - o, 10 - HOLD);
        chk("overflow held valid", int'(val[0]), 1);
        chk("overflow head token", int'({dat[0], eof[0]}), 2);
        rdy[0] = 1'b1;
        drain(HOLD + 4);
        chk("overflow readout drained", exp_q[0].size(), 0);
        chk("overflow valid cleared", int'(val[0]), 0);

        // Enable low after SOC abandons the frame: the idle bit yields no EOF.
        send_bit(2, 1, 8, 4, 0, 0);
        en[2] = 1'b0;
        tick();
        chk("enable low forces IDLE", int'(act[2]), 0);
        en[2] = 1'b1;
        send_bit(2, 2, 8, 4, 0, 0);
        frame(2, 8, 4, 2, 16'b10);
        drain(4);
        chk("sc8 queue drained", exp_q[2].size(), 0);

        // Reset mid bit 3.
        p = pat_cnt[0];
        send_bit(0, 1, 16, 4, 0, 0);
        push(0, 1'b1, 1'b0);
        send_bit(0, 1, 16, 4, 0, 0);
        push(0, 1'b0, 1'b0);
        send_bit(0, 0, 16, 4, 0, 0);
        send_bit(0, 1, 16, 4, 0, 40);
        chk("mid-frame rx_active", int'(act[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", int'({val[0], dat[0], eof[0], act[0], perr[0], ovf[0]}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        frame(0, 16, 4, 2, 16'b10);
        drain(4);
        chk("post-reset drained", exp_q[0].size(), 0);
        chk("reset no err_pattern", pat_cnt[0] - p, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm_subcarrier_decoder.md
# lm_subcarrier_decoder

Synthesizable decoder for the PICC load-modulator output stream: Manchester-coded bits with an on-off-keyed subcarrier. It samples `tx_out` once per carrier tick, classifies each bit period by per-sample mismatch counting with a configurable tolerance, and emits decoded bits plus an end-of-frame token through a valid/ready output. The block sits on the tx path as an in-loop monitor for loopback and self-test. Subcarrier period, bit length and error tolerance are all parameters.

## Interface
- `SC_TICKS`, 16: subcarrier period in clk ticks; even, ≥2.
- `SC_PER_HALF`, 4: subcarrier periods per half bit. HALF_TICKS = SC_TICKS*SC_PER_HALF; BIT_TICKS = 2*HALF_TICKS.
- `ERR_TOL`, 0: mismatched samples tolerated per bit. Constraint: 2*ERR_TOL < HALF_TICKS/2, enforced by elaboration assert.
- `FIFO_DEPTH`, 8: output token buffer depth; power of 2, ≥2. Used only with the FIFO macro.
- `clk`  in  1  carrier-rate clock; one tick per sample.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  decoder enable; low forces IDLE.
- `tx_out`  in  1  load-modulator output being decoded.
- `out_valid`  out  1  token available.
- `out_ready`  in  1  consumer accepts the token.
- `out_data`  out  1  decoded bit; 0 when `out_eof`=1.
- `out_eof`  out  1  token is the end-of-frame marker.
- `rx_active`  out  1  high in BIT state.
- `err_pattern`  out  1  one-cycle pulse on an invalid bit or a bad SOC.
- `err_overflow`  out  1  one-cycle pulse when a token is dropped.

## Operation
- Expected subcarrier at sample j within a half bit: sc(j) = ((j mod SC_TICKS) < SC_TICKS/2).
- Patterns, indexed by sample i within the bit:
  - P1: sc in the first half, 0 in the second.
  - P0: 0 in the first half, sc in the second.
  - PIDLE: all 0.
- States:
  - **IDLE**: the first `tx_out`=1 is bit sample index 0 → BIT, first_bit=1.
  - **BIT**: sample index counter runs 0..BIT_TICKS-1. Three mismatch counters (vs P1, P0, PIDLE) update every sample. Counter width is $clog2(BIT_TICKS+1).
  - **ERR_WAIT**: stays until BIT_TICKS consecutive `tx_out`=0 samples, then → IDLE. Any 1 restarts the count.
- Classification at the last sample (index BIT_TICKS-1), in priority order:
  1. Mismatch vs PIDLE ≤ ERR_TOL: write an EOF token and go to IDLE. If first_bit is set, raise `err_pattern` instead and write no token.
  2. Mismatch vs P1 ≤ ERR_TOL: if first_bit, consume as SOC and emit nothing; otherwise write data=1.
  3. Mismatch vs P0 ≤ ERR_TOL: if first_bit, raise `err_pattern` and go to ERR_WAIT; otherwise write data=0.
  4. No match: raise `err_pattern` and go to ERR_WAIT. No EOF is written.
- After each non-terminating bit, the index returns to 0 and first_bit clears.
- `enable` low: state goes to IDLE and all counters clear. A frame in progress is abandoned with no EOF. Buffered tokens are kept.
- Overflow: a write while the buffer is full drops the token and pulses `err_overflow`. A write coinciding with a read while full is accepted.

## Timing
- Reset values: all outputs 0, state IDLE, buffer empty.
- Token write happens on the edge that samples index BIT_TICKS-1.
- If the buffer was empty, `out_valid` is high immediately after that edge.
- `err_pattern` and `err_overflow` are asserted for the cycle following that same edge.
- Handshake: a transfer occurs when `out_valid` && `out_ready` at the clock edge. `out_data` and `out_eof` stay stable while `out_valid` && !`out_ready`.
- Decoder to output is zero-bubble: back-to-back tokens arrive at most one per BIT_TICKS.
- Reset asserted mid-frame: everything clears asynchronously, with no EOF and no error pulse.

## Configuration
- `LM_DECODER_FIFO_EN` defined: tokens pass through a FIFO_DEPTH-entry show-ahead FIFO.
- `LM_DECODER_FIFO_EN` undefined: a single output register.
  - A write while `out_valid` && !`out_ready` is an overflow: the token is dropped and `err_overflow` pulses.
  - A write coinciding with a transfer is accepted.

## Structure
- Package `lm_decoder_pkg` holds:
  - typedef `lm_token_t` (struct {data, eof});
  - state enum {IDLE, BIT, ERR_WAIT};
  - function `lm_expected_sc(idx, sc_ticks)`.
- Sub-module `lm_dec_fifo`: parametrised synchronous FIFO with async active-low reset, full/empty flags and show-ahead output. It is instantiated only under the macro.

## Test plan
- Defaults: SOC then bits 1,0,1 then an idle bit, `out_ready`=1 → tokens (1,0),(0,0),(1,0),(0,1) exactly; `err_pattern` never asserted.
- ERR_TOL=2:
  - 2 samples flipped in a 0-bit → decoded as 0.
  - 3 samples flipped → `err_pattern` pulse, state ERR_WAIT, no token until 128 zero samples.
- First bit sent as P0 → `err_pattern` pulse and no tokens.
- FIFO_DEPTH=8, `out_ready`=0, 9 data bits + EOF → 8 tokens held, `err_overflow` pulses twice, first 8 tokens read out in order.
- `rst_n` asserted mid-bit 3 → all outputs 0 the same cycle; the next frame decodes correctly.
- SC_TICKS=8, SC_PER_HALF=4 (64-tick bits), bits 0,1 → tokens (0,0),(1,0),(0,1).
